// File: rtl/step_ramp_pkg.sv
// rtl/step_ramp_pkg.sv - shared state encodings and default width for the step ramp
package step_ramp_pkg;

  localparam int DEF_SIZE = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEL  = 2'd1,
    ST_CRUISE = 2'd2,
    ST_DECEL  = 2'd3
  } state_e;

endpackage

// File: rtl/step_ramp_if.sv
// rtl/step_ramp_if.sv - command/status bundle between motion controller and step ramp
interface step_ramp_if
  import step_ramp_pkg::*;
#(
  parameter int SIZE = DEF_SIZE
);

  logic            start_in;
  logic            stop_in;
  logic [SIZE-1:0] target_in;
  logic [SIZE-1:0] speed_out;
  logic            step_enable_out;
  logic            busy_out;
  logic            done_out;
  logic [1:0]      state_out;

  modport master (
    output start_in, stop_in, target_in,
    input  speed_out, step_enable_out, busy_out, done_out, state_out
  );

  modport slave (
    input  start_in, stop_in, target_in,
    output speed_out, step_enable_out, busy_out, done_out, state_out
  );

endinterface

// File: rtl/step_ramp_ramp_tick.sv
// rtl/step_ramp_ramp_tick.sv - free-running ramp update tick divider
module ramp_tick #(
  parameter int RAMP_DIV = 50000
) (
  input  logic clk_in,
  input  logic reset_n_in,
  input  logic clear_in,
  input  logic run_in,
  output logic tick_out
);

  localparam int            CW   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_in) begin
      cnt_d = '0;
    end else if (run_in) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_out = (cnt_q == LAST);

endmodule

// File: rtl/step_ramp.sv
// rtl/step_ramp.sv - trapezoidal step-divider profile generator feeding the motor driver
module step_ramp
  import step_ramp_pkg::*;
#(
  parameter int              SIZE        = DEF_SIZE,
  parameter int              RAMP_DIV    = 50000,
  parameter logic [SIZE-1:0] DELTA       = 64'd100,
  parameter logic [SIZE-1:0] SLOW_PERIOD = 64'd100000,
  parameter logic [SIZE-1:0] MIN_PERIOD  = 64'd2
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  step_ramp_if.slave  bus
);

  state_e          state_q, state_d;
  logic [SIZE-1:0] speed_q, speed_d;
  logic [SIZE-1:0] tgt_q, tgt_d;
  logic            en_q, en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tick;
  logic            clear_tick;

  ramp_tick #(
    .RAMP_DIV (RAMP_DIV)
  ) u_ramp_tick (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .clear_in   (clear_tick),
    .run_in     (state_q != ST_IDLE),
    .tick_out   (tick)
  );

  always_comb begin
    state_d    = state_q;
    speed_d    = speed_q;
    tgt_d      = tgt_q;
    en_d       = en_q;
    done_d     = 1'b0;
    clear_tick = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_in) begin
          state_d    = ST_ACCEL;
          en_d       = 1'b1;
          clear_tick = 1'b1;
          if (bus.target_in < MIN_PERIOD) begin
            tgt_d = MIN_PERIOD;
          end else if (bus.target_in > SLOW_PERIOD) begin
            tgt_d = SLOW_PERIOD;
          end else begin
            tgt_d = bus.target_in;
          end
        end
      end
      ST_ACCEL: begin
        // Stop beats a same-cycle tick; compare against tgt+DELTA so speed never underflows.
        if (bus.stop_in) begin
          state_d = ST_DECEL;
        end else if (tick) begin
          if (speed_q <= tgt_q + DELTA) begin
            speed_d = tgt_q;
            state_d = ST_CRUISE;
          end else begin
            speed_d = speed_q - DELTA;
          end
        end
      end
      ST_CRUISE: begin
        if (bus.stop_in) begin
          state_d = ST_DECEL;
        end
      end
      ST_DECEL: begin
        if (tick) begin
          if (speed_q >= SLOW_PERIOD - DELTA) begin
            speed_d = SLOW_PERIOD;
            en_d    = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            speed_d = speed_q + DELTA;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= ST_IDLE;
      speed_q <= SLOW_PERIOD;
      tgt_q   <= SLOW_PERIOD;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      tgt_q   <= tgt_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.speed_out       = speed_q;
  assign bus.step_enable_out = en_q;
  assign bus.busy_out        = busy_q;
  assign bus.done_out        = done_q;
  assign bus.state_out       = state_q;

endmodule

// File: tb/tb_step_ramp.sv
// tb/tb_step_ramp.sv - directed-vector bench for step_ramp
module tb_step_ramp;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  step_ramp_if #(.SIZE(64)) bus ();

  step_ramp #(
    .SIZE        (64),
    .RAMP_DIV    (4),
    .DELTA       (64'd100),
    .SLOW_PERIOD (64'd1000),
    .MIN_PERIOD  (64'd2)
  ) dut (
    .clk_in     (clk),
    .reset_n_in (rst_n),
    .bus        (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outs(input string tag, input logic [63:0] spd, input logic [1:0] st,
                            input logic en, input logic done);
    check({tag, ".speed"}, bus.speed_out, spd);
    check({tag, ".state"}, 64'(bus.state_out), 64'(st));
    check({tag, ".en"}, 64'(bus.step_enable_out), 64'(en));
    check({tag, ".busy"}, 64'(bus.busy_out), 64'(st != 2'd0));
    check({tag, ".done"}, 64'(bus.done_out), 64'(done));
  endtask

  task automatic start_motion(input logic [63:0] tgt);
    bus.target_in = tgt;
    bus.start_in  = 1'b1;
    cyc(1);
    bus.start_in  = 1'b0;
    check_outs("start", 64'd1000, 2'd1, 1'b1, 1'b0);
  endtask

  task automatic pulse_stop();
    bus.stop_in = 1'b1;
    cyc(1);
    bus.stop_in = 1'b0;
  endtask

  task automatic next_change(input string tag, input logic [63:0] exp);
    logic [63:0] prev;
    int k;
    prev = bus.speed_out;
    k = 0;
    while (bus.speed_out == prev && k < 4) begin
      cyc(1);
      k++;
    end
    check(tag, bus.speed_out, exp);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (bus.state_out != 2'd0 && k < budget) begin
      cyc(1);
      k++;
    end
    check("wait_idle", 64'(bus.state_out), 64'd0);
    check("wait_idle.speed", bus.speed_out, 64'd1000);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b1;
    bus.start_in  = 1'b0;
    bus.stop_in   = 1'b0;
    bus.target_in = 64'd0;

    // 1: asynchronous reset mid-cycle
    #12 rst_n = 1'b0;
    #1 check_outs("reset", 64'd1000, 2'd0, 1'b0, 1'b0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    check_outs("post_reset", 64'd1000, 2'd0, 1'b0, 1'b0);

    // 2: accel to 500, cruise holds and ignores start
    start_motion(64'd500);
    for (int i = 1; i <= 5; i++) begin
      cyc(4);
      check("accel500", bus.speed_out, 64'(1000 - 100 * i));
    end
    check("cruise500.state", 64'(bus.state_out), 64'd2);
    bus.target_in = 64'd900;
    bus.start_in  = 1'b1;
    cyc(1);
    bus.start_in  = 1'b0;
    cyc(3);
    check_outs("cruise500.hold", 64'd500, 2'd2, 1'b1, 1'b0);

    // 4: stop from cruise, decel back to idle with one-cycle done
    pulse_stop();
    check_outs("decel.entry", 64'd500, 2'd3, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      next_change("decel500", 64'(500 + 100 * i));
    end
    next_change("decel.end", 64'd1000);
    check_outs("decel.idle", 64'd1000, 2'd0, 1'b0, 1'b1);
    cyc(1);
    check("done.one_cycle", 64'(bus.done_out), 64'd0);

    // 3: target 550 clamps the last step
    start_motion(64'd550);
    for (int i = 1; i <= 4; i++) begin
      cyc(4);
      check("accel550", bus.speed_out, 64'(1000 - 100 * i));
    end
    cyc(4);
    check_outs("cruise550", 64'd550, 2'd2, 1'b1, 1'b0);
    pulse_stop();
    wait_idle(40);
    cyc(1);

    // 5: start+stop together on a tick at 800: stop wins
    start_motion(64'd500);
    cyc(4);
    check("accel.900", bus.speed_out, 64'd900);
    cyc(4);
    check("accel.800", bus.speed_out, 64'd800);
    cyc(3);
    bus.start_in = 1'b1;
    bus.stop_in  = 1'b1;
    cyc(1);
    bus.start_in = 1'b0;
    bus.stop_in  = 1'b0;
    check_outs("stopwins", 64'd800, 2'd3, 1'b1, 1'b0);
    cyc(4);
    check_outs("stopwins.900", 64'd900, 2'd3, 1'b1, 1'b0);
    cyc(4);
    check_outs("stopwins.idle", 64'd1000, 2'd0, 1'b0, 1'b1);
    cyc(1);

    // 6a: target 0 clamps to MIN_PERIOD=2 after ten ticks
    start_motion(64'd0);
    cyc(36);
    check_outs("min.100", 64'd100, 2'd1, 1'b1, 1'b0);
    cyc(4);
    check_outs("min.2", 64'd2, 2'd2, 1'b1, 1'b0);
    pulse_stop();
    wait_idle(60);
    cyc(1);

    // 6b: target above SLOW_PERIOD cruises at 1000 on the first tick
    start_motion(64'd5000);
    cyc(3);
    check_outs("slow.pre", 64'd1000, 2'd1, 1'b1, 1'b0);
    cyc(1);
    check_outs("slow.cruise", 64'd1000, 2'd2, 1'b1, 1'b0);

    // 6c: reset mid-decel, no done pulse
    pulse_stop();
    check("slow.decel", 64'(bus.state_out), 64'd3);
    #2 rst_n = 1'b0;
    #1 check_outs("rst_decel", 64'd1000, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(1);
      check("rst_decel.nodone", 64'(bus.done_out), 64'd0);
    end
    rst_n = 1'b1;
    cyc(6);
    check_outs("rst_decel.after", 64'd1000, 2'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
